cfg_write_arbiter: RTL and testbench



---
 rtl/cfg_arb_pkg.sv | 45 ++++
 rtl/cfg_write_arbiter_rr_arb2.sv | 31 +++
 rtl/cfg_write_arbiter.sv | 135 +++++++++++++
 tb/tb_cfg_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_arb_pkg.sv
// Shared definitions for the configuration-bank write arbiter: register map,
// commit-state encoding and the write-address decoder.
package cfg_arb_pkg;

  localparam int unsigned ADDR_OUT_LO = 0;
  localparam int unsigned ADDR_OUT_HI = 1;
  localparam int unsigned ADDR_PWM_LO = 2;
  localparam int unsigned ADDR_PWM_HI = 3;
  localparam int unsigned ADDR_DUTY   = 4;
  localparam int unsigned ADDR_FLUSH  = 5;
  localparam int unsigned NUM_REGS    = 5;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    DIRTY = 2'd1,
    FLUSH = 2'd2
  } commit_state_e;

  typedef enum logic [1:0] {
    DEC_REG   = 2'd0,
    DEC_FLUSH = 2'd1,
    DEC_ERR   = 2'd2
  } dec_kind_e;

  typedef struct packed {
    dec_kind_e        kind;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Classify a write address as a bank register, the flush command, or out of range.
  function automatic dec_t decode(input logic [31:0] addr);
    dec_t d;
    d.kind = DEC_ERR;
    d.idx  = '0;
    if (addr < 32'(NUM_REGS)) begin
      d.kind = DEC_REG;
      d.idx  = IDX_W'(addr);
    end else if (addr == 32'(ADDR_FLUSH)) begin
      d.kind = DEC_FLUSH;
    end
    return d;
  endfunction

endpackage

// File: rtl/cfg_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grant vector is combinational, the priority
// pointer moves to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Grant to requester 0 hands priority to 1 and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (|gnt) begin
      rr_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/cfg_write_arbiter.sv
// Arbitrates SPI and sequencer writes into a shadow configuration bank and
// commits it atomically to the active bank on a PWM period boundary or flush.
// Optional: CFG_ERR_COUNT_EN adds a saturating dropped-write counter (err_count).
module cfg_write_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int unsigned SYNC_COMMIT = 1,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              period_sync,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              pending,
  output logic              wr_err
`ifdef CFG_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  logic [1:0]        gnt;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  dec_t              dec;
  logic              shadow_wr;
  logic              flush_wr;
  logic              err_wr;
  logic              commit_cond;
  logic              commit;
  commit_state_e     state;
  commit_state_e     next_state;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign wr_fire     = |gnt;
  assign wr_addr     = gnt[1] ? req1_addr : req0_addr;
  assign wr_data     = gnt[1] ? req1_data : req0_data;
  assign dec         = decode(32'(wr_addr));
  assign shadow_wr   = wr_fire && (dec.kind == DEC_REG);
  assign flush_wr    = wr_fire && (dec.kind == DEC_FLUSH) && wr_data[0];
  assign err_wr      = wr_fire && (dec.kind == DEC_ERR);
  assign commit_cond = period_sync || (SYNC_COMMIT == 0);

  // Commit state machine: a write landing in the commit cycle keeps the bank dirty.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      CLEAN: begin
        if (shadow_wr) next_state = DIRTY;
      end
      DIRTY: begin
        if (commit_cond) begin
          commit     = 1'b1;
          next_state = shadow_wr ? DIRTY : CLEAN;
        end else if (flush_wr) begin
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        commit     = 1'b1;
        next_state = shadow_wr ? DIRTY : CLEAN;
      end
      default: next_state = CLEAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAN;
      pending <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= (next_state != CLEAN);
      wr_err  <= err_wr;
    end
  end

  // Active bank samples the pre-write shadow values on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
      end
      if (shadow_wr) shadow[dec.idx] <= wr_data;
    end
  end

`ifdef CFG_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (err_wr && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end
`endif

  assign en_reg_out_7_0  = active[IDX_W'(ADDR_OUT_LO)];
  assign en_reg_out_15_8 = active[IDX_W'(ADDR_OUT_HI)];
  assign en_reg_pwm_7_0  = active[IDX_W'(ADDR_PWM_LO)];
  assign en_reg_pwm_15_8 = active[IDX_W'(ADDR_PWM_HI)];
  assign pwm_duty_cycle  = active[IDX_W'(ADDR_DUTY)];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Self-checking bench for cfg_write_arbiter: directed scenarios plus a
// randomized run against a bank/queue-level reference model.
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       period_sync;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       pending, wr_err;
`ifdef CFG_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  cfg_write_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .period_sync     (period_sync),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .pending         (pending),
    .wr_err          (wr_err)
`ifdef CFG_ERR_COUNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: shadow/active arrays, a "something uncommitted" flag,
  // an "armed flush" flag and the requester that wins the next tie.
  logic [7:0] m_shadow [5];
  logic [7:0] m_active [5];
  bit         m_dirty, m_flush, m_tie_to_1, m_err;
  int         m_errcnt;
  bit         exp_r0, exp_r1, obs_r0, obs_r1;

  wire [41:0] dut_bank = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                          en_reg_pwm_15_8, pwm_duty_cycle, pending, wr_err};

  function automatic logic [41:0] model_bank();
    return {m_active[0], m_active[1], m_active[2], m_active[3], m_active[4],
            1'(m_dirty || m_flush), 1'(m_err)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_dirty = 0; m_flush = 0; m_tie_to_1 = 0; m_err = 0; m_errcnt = 0;
  endfunction

  task automatic drive_idle();
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    period_sync = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // One clock: apply inputs, capture readies, advance the model, land on the next negedge.
  task automatic cycle(input bit v0, input logic [6:0] a0, input logic [7:0] d0,
                       input bit v1, input logic [6:0] a1, input logic [7:0] d1,
                       input bit sync);
    bit acc, commit, is_flush;
    logic [6:0] a;
    logic [7:0] d;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    period_sync = sync;
    #1;
    exp_r0 = v0 && (!v1 || !m_tie_to_1);
    exp_r1 = v1 && (!v0 || m_tie_to_1);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    acc = exp_r0 || exp_r1;
    a = exp_r1 ? a1 : a0;
    d = exp_r1 ? d1 : d0;
    commit = m_flush || (m_dirty && sync);
    if (commit) for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
    m_err = acc && (a >= 7'd6);
    if (m_err && m_errcnt < 255) m_errcnt++;
    is_flush = acc && (a == 7'd5) && d[0];
    m_flush = is_flush && m_dirty && !commit;
    if (acc && a < 7'd5) begin
      m_shadow[a] = d;
      m_dirty = 1;
    end else if (commit) begin
      m_dirty = 0;
    end
    if (acc) m_tie_to_1 = exp_r0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dut_bank !== 42'd0) begin
      bad++; $display("FAIL reset_bank got=%h exp=%h", dut_bank, 42'd0);
    end
    rst_n = 1;
    @(negedge clk);
    total++;
    if (dut_bank !== model_bank()) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", dut_bank, model_bank());
    end
`ifdef CFG_ERR_COUNT_EN
    total++;
    if (err_count !== 8'h00) begin
      bad++; $display("FAIL reset_errcnt got=%h exp=00", err_count);
    end
`endif
  endtask

  task automatic test_sync_commit();
    do_reset();
    cycle(1, 7'd4, 8'h80, 0, 7'd0, 8'h00, 0);
    total++;
    if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
      bad++; $display("FAIL single_ready got=%b%b exp=01", obs_r1, obs_r0);
    end
    total++;
    if (pwm_duty_cycle !== 8'h00 || pending !== 1'b1) begin
      bad++; $display("FAIL staged_hold got duty=%h pend=%b exp duty=00 pend=1", pwm_duty_cycle, pending);
    end
    cycle(0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1);
    total++;
    if (pwm_duty_cycle !== 8'h80 || pending !== 1'b0) begin
      bad++; $display("FAIL sync_commit got duty=%h pend=%b exp duty=80 pend=0", pwm_duty_cycle, pending);
    end
  endtask

  task automatic test_alternation();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, 7'd0, 8'h11, 1, 7'd1, 8'h22, 0);
      total++;
      if (obs_r0 !== bit'(k % 2 == 0) || obs_r1 !== bit'(k % 2 == 1)) begin
        bad++; $display("FAIL alt_grant k=%0d got=%b%b exp=%b%b", k, obs_r1, obs_r0,
                        bit'(k % 2 == 1), bit'(k % 2 == 0));
      end
    end
    total++;
    if (dut_bank !== model_bank()) begin
      bad++; $display("FAIL alt_bank got=%h exp=%h", dut_bank, model_bank());
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    cycle(0, 7'd0, 8'h00, 1, 7'd7, 8'hAA, 0);
    total++;
    if (obs_r1 !== 1'b1) begin
      bad++; $display("FAIL bad_ready got=%b exp=1", obs_r1);
    end
    total++;
    if (wr_err !== 1'b1 || dut_bank !== model_bank()) begin
      bad++; $display("FAIL bad_err got=%h exp=%h", dut_bank, model_bank());
    end
    cycle(0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1);
    total++;
    if (wr_err !== 1'b0 || dut_bank !== 42'd0) begin
      bad++; $display("FAIL bad_pulse got=%h exp=%h", dut_bank, 42'd0);
    end
`ifdef CFG_ERR_COUNT_EN
    total++;
    if (err_count !== 8'h01) begin
      bad++; $display("FAIL errcnt_one got=%h exp=01", err_count);
    end
    for (int k = 0; k < 300; k++) cycle(1, 7'(6 + k % 100), 8'h55, 0, 7'd0, 8'h00, 0);
    total++;
    if (err_count !== 8'hFF) begin
      bad++; $display("FAIL errcnt_sat got=%h exp=ff", err_count);
    end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 7'd2, 8'h0F, 0, 7'd0, 8'h00, 0);
    cycle(0, 7'd0, 8'h00, 1, 7'd5, 8'h01, 0);
    total++;
    if (en_reg_pwm_7_0 !== 8'h00 || pending !== 1'b1) begin
      bad++; $display("FAIL flush_armed got pwm=%h pend=%b exp pwm=00 pend=1", en_reg_pwm_7_0, pending);
    end
    cycle(0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 0);
    total++;
    if (en_reg_pwm_7_0 !== 8'h0F || pending !== 1'b0) begin
      bad++; $display("FAIL flush_commit got pwm=%h pend=%b exp pwm=0f pend=0", en_reg_pwm_7_0, pending);
    end
    cycle(1, 7'd5, 8'h01, 0, 7'd0, 8'h00, 0);
    total++;
    if (pending !== 1'b0 || wr_err !== 1'b0) begin
      bad++; $display("FAIL flush_clean got pend=%b err=%b exp 0 0", pending, wr_err);
    end
  endtask

  task automatic test_write_with_commit();
    do_reset();
    cycle(1, 7'd3, 8'h05, 0, 7'd0, 8'h00, 0);
    cycle(1, 7'd3, 8'h01, 0, 7'd0, 8'h00, 1);
    total++;
    if (en_reg_pwm_15_8 !== 8'h05 || pending !== 1'b1) begin
      bad++; $display("FAIL same_cycle got pwm_hi=%h pend=%b exp 05 1", en_reg_pwm_15_8, pending);
    end
    cycle(0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1);
    total++;
    if (en_reg_pwm_15_8 !== 8'h01 || pending !== 1'b0) begin
      bad++; $display("FAIL next_sync got pwm_hi=%h pend=%b exp 01 0", en_reg_pwm_15_8, pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 7'd4, 8'h40, 0, 7'd0, 8'h00, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    total++;
    if (dut_bank !== 42'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", dut_bank, 42'd0);
    end
    @(negedge clk);
    rst_n = 1;
    cycle(0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1);
    cycle(0, 7'd0, 8'h00, 0, 7'd0, 8'h00, 1);
    total++;
    if (pwm_duty_cycle !== 8'h00 || pending !== 1'b0) begin
      bad++; $display("FAIL no_replay got duty=%h pend=%b exp 00 0", pwm_duty_cycle, pending);
    end
  endtask

  function automatic logic [6:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r <= 5) return 7'(r);
    return 7'($urandom_range(6, 127));
  endfunction

  task automatic test_random();
    bit         hv [2];
    logic [6:0] ha [2];
    logic [7:0] hd [2];
    do_reset();
    for (int r = 0; r < 2; r++) hv[r] = 0;
    for (int k = 0; k < 2000; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!hv[r] && $urandom_range(0, 1) == 1) begin
          hv[r] = 1;
          ha[r] = rand_addr();
          hd[r] = 8'($urandom);
        end
      end
      cycle(hv[0], ha[0], hd[0], hv[1], ha[1], hd[1], $urandom_range(0, 3) == 0);
      total++;
      if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        bad++; $display("FAIL rand_ready k=%0d got=%b%b exp=%b%b", k, obs_r1, obs_r0, exp_r1, exp_r0);
      end
      total++;
      if (dut_bank !== model_bank()) begin
        bad++; $display("FAIL rand_bank k=%0d got=%h exp=%h", k, dut_bank, model_bank());
      end
`ifdef CFG_ERR_COUNT_EN
      total++;
      if (err_count !== 8'(m_errcnt)) begin
        bad++; $display("FAIL rand_errcnt k=%0d got=%h exp=%h", k, err_count, 8'(m_errcnt));
      end
`endif
      if (exp_r0) hv[0] = 0;
      if (exp_r1) hv[1] = 0;
    end
  endtask

  initial begin
    test_reset();
    test_sync_commit();
    test_alternation();
    test_bad_addr();
    test_flush();
    test_write_with_commit();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
